peripheral_comms_mc: RTL

Multi-channel, FIFO-buffered serial transmit peripheral for the J1 SoC I/O bus. It is the parametrised successor of the single-channel communications peripheral. It adds N independent 8N1 transmitters, each with its own transmit FIFO, a runtime baud divisor, status flags and a sticky overflow flag. It sits behind one chip-select of the SoC address decoder, and its `d_out` feeds the J1 read mux.

---
 rtl/peripheral_comms_mc_if.sv | 12 +
 rtl/peripheral_comms_mc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_comms_mc_if.sv
// J1 I/O-bus port bundle for peripheral_comms_mc: write data, strobes, address and read data.
interface peripheral_comms_mc_if;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;

    modport master (output d_in, cs, addr, rd, wr, input d_out);
    modport slave  (input d_in, cs, addr, rd, wr, output d_out);
endinterface

// File: rtl/peripheral_comms_mc.sv
// peripheral_comms_mc: NUM_CH FIFO-buffered 8N1 serial transmitters behind one J1 chip-select.
// Define COMMS_PARITY_EN to build CTRL bit2 (even parity bit before stop, 11*DIV frames).
module peripheral_comms_mc #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    peripheral_comms_mc_if.slave bus,
    output logic [NUM_CH-1:0]    tx,
    output logic [NUM_CH-1:0]    busy
);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} tx_state_e;

    logic [15:0] ch_rdata [4];
    logic        rd_c;
    logic [15:0] d_out_q;

    for (genvar c = 0; c < 4; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            logic [7:0]    mem_q [FIFO_DEPTH];
            logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, cnt_c;
            logic          sel_c, wr_c, st_rd_c, push_c, pop_c, flush_c, ovf_set_c;
            logic          full_c, empty_c, can_start_c, pctl_c;
            logic [15:0]   div_q, div_d, div_m1_c, bcnt_q, bcnt_d;
            logic [7:0]    head_c, sh_q, sh_d;
            logic [2:0]    bidx_q, bidx_d;
            logic          en_q, en_d, ovf_q, ovf_d, tx_q, tx_d, busy_q, busy_d;
            tx_state_e     state_q, state_d;
`ifdef COMMS_PARITY_EN
            logic          pctl_q, pctl_d, pen_q, pen_d, par_q, par_d;
            assign pctl_c = pctl_q;
`else
            assign pctl_c = 1'b0;
`endif

            assign sel_c       = bus.cs && (bus.addr[3:2] == 2'(c));
            assign wr_c        = sel_c && bus.wr;
            assign st_rd_c     = sel_c && bus.rd && !bus.wr && (bus.addr[1:0] == REG_STATUS);
            assign cnt_c       = wptr_q - rptr_q;
            assign empty_c     = (cnt_c == '0);
            assign full_c      = (cnt_c == PW'(FIFO_DEPTH));
            assign head_c      = mem_q[rptr_q[AW-1:0]];
            assign can_start_c = en_q && !empty_c;
            assign div_m1_c    = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
            // A byte is popped only when a new frame is launched (from IDLE or the last STOP clock).
            assign pop_c       = can_start_c &&
                                 ((state_q == S_IDLE) || ((state_q == S_STOP) && (bcnt_q == 16'd0)));
            assign flush_c     = wr_c && (bus.addr[1:0] == REG_CTRL) && bus.d_in[1];
            assign push_c      = wr_c && (bus.addr[1:0] == REG_DATA) && (!full_c || pop_c);
            assign ovf_set_c   = wr_c && (bus.addr[1:0] == REG_DATA) && full_c && !pop_c;

            // Serial framer: bit period reloads from DIV at every bit boundary.
            always_comb begin
                state_d = state_q;
                bcnt_d  = bcnt_q - 16'd1;
                sh_d    = sh_q;
                bidx_d  = bidx_q;
                tx_d    = tx_q;
`ifdef COMMS_PARITY_EN
                pen_d   = pen_q;
                par_d   = par_q;
`endif
                case (state_q)
                    S_IDLE: begin
                        bcnt_d = bcnt_q;
                        tx_d   = 1'b1;
                    end
                    S_START: if (bcnt_q == 16'd0) begin
                        state_d = S_DATA;
                        tx_d    = sh_q[0];
                        sh_d    = {1'b0, sh_q[7:1]};
                        bidx_d  = 3'd0;
                        bcnt_d  = div_m1_c;
                    end
                    S_DATA: if (bcnt_q == 16'd0) begin
                        bcnt_d = div_m1_c;
                        if (bidx_q == 3'd7) begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
`ifdef COMMS_PARITY_EN
                            if (pen_q) begin
                                state_d = S_PAR;
                                tx_d    = par_q;
                            end
`endif
                        end else begin
                            tx_d   = sh_q[0];
                            sh_d   = {1'b0, sh_q[7:1]};
                            bidx_d = bidx_q + 3'd1;
                        end
                    end
                    S_PAR: if (bcnt_q == 16'd0) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                        bcnt_d  = div_m1_c;
                    end
                    S_STOP: if (bcnt_q == 16'd0) begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        bcnt_d  = 16'd0;
                    end
                    default: state_d = S_IDLE;
                endcase
                if (pop_c) begin
                    state_d = S_START;
                    sh_d    = head_c;
                    tx_d    = 1'b0;
                    bcnt_d  = div_m1_c;
`ifdef COMMS_PARITY_EN
                    pen_d   = pctl_q;
                    par_d   = ^head_c;
`endif
                end
            end

            always_comb begin
                wptr_d = push_c ? wptr_q + PW'(1) : wptr_q;
                rptr_d = flush_c ? wptr_q : (pop_c ? rptr_q + PW'(1) : rptr_q);
                en_d   = en_q;
                div_d  = div_q;
`ifdef COMMS_PARITY_EN
                pctl_d = pctl_q;
`endif
                if (wr_c && (bus.addr[1:0] == REG_CTRL)) begin
                    en_d   = bus.d_in[0];
`ifdef COMMS_PARITY_EN
                    pctl_d = bus.d_in[2];
`endif
                end
                if (wr_c && (bus.addr[1:0] == REG_DIV)) div_d = bus.d_in;
                ovf_d  = ovf_set_c ? 1'b1 : (st_rd_c ? 1'b0 : ovf_q);
                busy_d = (state_d != S_IDLE) || (wptr_d != rptr_d);
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= S_IDLE;
                    wptr_q  <= '0;
                    rptr_q  <= '0;
                    bcnt_q  <= '0;
                    sh_q    <= '0;
                    bidx_q  <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    en_q    <= 1'b1;
                    ovf_q   <= 1'b0;
                    div_q   <= DIV_RST;
`ifdef COMMS_PARITY_EN
                    pctl_q  <= 1'b0;
                    pen_q   <= 1'b0;
                    par_q   <= 1'b0;
`endif
                end else begin
                    state_q <= state_d;
                    wptr_q  <= wptr_d;
                    rptr_q  <= rptr_d;
                    bcnt_q  <= bcnt_d;
                    sh_q    <= sh_d;
                    bidx_q  <= bidx_d;
                    tx_q    <= tx_d;
                    busy_q  <= busy_d;
                    en_q    <= en_d;
                    ovf_q   <= ovf_d;
                    div_q   <= div_d;
`ifdef COMMS_PARITY_EN
                    pctl_q  <= pctl_d;
                    pen_q   <= pen_d;
                    par_q   <= par_d;
`endif
                end
            end

            always_ff @(posedge clk) begin
                if (push_c) mem_q[wptr_q[AW-1:0]] <= bus.d_in[7:0];
            end

            always_comb begin
                case (bus.addr[1:0])
                    REG_STATUS: ch_rdata[c] = {8'(cnt_c), 4'b0, ovf_q, full_c, empty_c, busy_q};
                    REG_CTRL:   ch_rdata[c] = {13'b0, pctl_c, 1'b0, en_q};
                    REG_DIV:    ch_rdata[c] = div_q;
                    default:    ch_rdata[c] = 16'h0000;
                endcase
            end

            assign tx[c]   = tx_q;
            assign busy[c] = busy_q;
        end else begin : g_off
            assign ch_rdata[c] = 16'h0000;
        end
    end

    assign rd_c = bus.cs && bus.rd && !bus.wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      d_out_q <= '0;
        else if (rd_c) d_out_q <= ch_rdata[bus.addr[3:2]];
    end

    assign bus.d_out = d_out_q;
endmodule
